// File: rtl/cycle_timing_gen_if.sv
// Strobe/status bundle between the control unit (master) and the
// machine-cycle/beat generator (slave).
interface cycle_timing_gen_if #(
    parameter int unsigned T_WIDTH = 8
);
    logic               Tplus1;
    logic               Tset0;
    logic               Set_FI;
    logic               Set_DST;
    logic               Set_SRC;
    logic               Set_EXC;
    logic               HALT;
    logic               int_req;
    logic               int_en;
    logic               FI;
    logic               DST;
    logic               SRC;
    logic               EXC;
    logic               INT;
    logic [T_WIDTH-1:0] T;
    logic               int_ack;
    logic               halted;
    logic               seq_err;

    modport master (
        output Tplus1, Tset0, Set_FI, Set_DST, Set_SRC, Set_EXC, HALT, int_req, int_en,
        input  FI, DST, SRC, EXC, INT, T, int_ack, halted, seq_err
    );

    modport slave (
        input  Tplus1, Tset0, Set_FI, Set_DST, Set_SRC, Set_EXC, HALT, int_req, int_en,
        output FI, DST, SRC, EXC, INT, T, int_ack, halted, seq_err
    );
endinterface

// File: rtl/cycle_timing_gen.sv
// Machine-cycle and beat generator: one-hot cycle and beat vectors stepped by
// CU strobes, plus the autonomous INT cycle, HALT freeze and sequencing-fault watch.
module cycle_timing_gen #(
    parameter int unsigned T_WIDTH     = 8,
    parameter int unsigned INT_BEATS   = 4,
    parameter int unsigned STALL_LIMIT = 16
) (
    input logic                clk,
    input logic                rst,
    cycle_timing_gen_if.slave  bus
);
    localparam int unsigned SW = $clog2(STALL_LIMIT + 1);
    localparam logic [T_WIDTH-1:0] T0     = T_WIDTH'(1);
    localparam logic [T_WIDTH-1:0] T_LAST = T0 << (T_WIDTH - 1);
    localparam logic [T_WIDTH-1:0] T_ACK  = T0 << (INT_BEATS - 1);

    // Encoding is one-hot so the cycle outputs come straight off the register.
    typedef enum logic [4:0] {
        CYC_FI  = 5'b00001,
        CYC_DST = 5'b00010,
        CYC_SRC = 5'b00100,
        CYC_EXC = 5'b01000,
        CYC_INT = 5'b10000
    } cyc_e;

    cyc_e               cyc_q, cyc_d;
    logic [T_WIDTH-1:0] t_q, t_d;
    logic               ack_q, ack_d;
    logic               halted_q, halted_d;
    logic               err_q, err_d;
    logic [SW-1:0]      stall_q, stall_d;

    logic [3:0] set_vec;
    logic       any_set;
    logic       multi_set;
    logic       strobe;
    logic       irq;

    always_comb begin
        set_vec   = {bus.Set_EXC, bus.Set_SRC, bus.Set_DST, bus.Set_FI};
        any_set   = |set_vec;
        multi_set = |(set_vec & (set_vec - 4'd1));
        strobe    = any_set | bus.Tplus1 | bus.Tset0;
        irq       = bus.int_req & bus.int_en;
    end

    always_comb begin
        cyc_d    = cyc_q;
        t_d      = t_q;
        halted_d = halted_q;
        err_d    = err_q;
        stall_d  = stall_q;

        if (halted_q) begin
            stall_d = '0;
            if (irq) begin
                halted_d = 1'b0;
                cyc_d    = CYC_INT;
                t_d      = T0;
            end
        end else if (cyc_q == CYC_INT) begin
            stall_d = '0;
            if (t_q == T_ACK) begin
                cyc_d = CYC_FI;
                t_d   = T0;
            end else begin
                t_d = t_q << 1;
            end
        end else begin
            if (any_set) begin
                t_d = T0;
                if (multi_set) err_d = 1'b1;
                if (bus.Set_EXC)      cyc_d = CYC_EXC;
                else if (bus.Set_SRC) cyc_d = CYC_SRC;
                else if (bus.Set_DST) cyc_d = CYC_DST;
                else if (cyc_q == CYC_EXC && irq) begin
                    // Instruction end: a pending interrupt wins over HALT.
                    cyc_d = CYC_INT;
                end else begin
                    cyc_d = CYC_FI;
                    if (cyc_q == CYC_EXC && bus.HALT) halted_d = 1'b1;
                end
            end else if (bus.Tset0) begin
                t_d = T0;
            end else if (bus.Tplus1) begin
                if (t_q == T_LAST) err_d = 1'b1;
                else               t_d   = t_q << 1;
            end

            if (strobe) begin
                stall_d = '0;
            end else if (stall_q >= SW'(STALL_LIMIT - 1)) begin
                stall_d = SW'(STALL_LIMIT);
                err_d   = 1'b1;
            end else begin
                stall_d = stall_q + SW'(1);
            end
        end

        ack_d = (cyc_d == CYC_INT) && (t_d == T_ACK);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_q    <= CYC_FI;
            t_q      <= T0;
            ack_q    <= 1'b0;
            halted_q <= 1'b0;
            err_q    <= 1'b0;
            stall_q  <= '0;
        end else begin
            cyc_q    <= cyc_d;
            t_q      <= t_d;
            ack_q    <= ack_d;
            halted_q <= halted_d;
            err_q    <= err_d;
            stall_q  <= stall_d;
        end
    end

    assign bus.FI      = cyc_q[0];
    assign bus.DST     = cyc_q[1];
    assign bus.SRC     = cyc_q[2];
    assign bus.EXC     = cyc_q[3];
    assign bus.INT     = cyc_q[4];
    assign bus.T       = t_q;
    assign bus.int_ack = ack_q;
    assign bus.halted  = halted_q;
    assign bus.seq_err = err_q;
endmodule
